temporizador_rodada: RTL and testbench

Round countdown timer sitting directly downstream of the game controller. Consumes the controller's timer commands (zeraT, contaT, decresceT) and returns fimT when the player's time for the current square runs out. The per-round time limit shrinks by a fixed step each time decresceT pulses, down to a floor, which raises difficulty as the game progresses. Also exports remaining seconds for the 7-segment path.

---
 rtl/temporizador_rodada_pkg.sv | 18 +
 rtl/temporizador_rodada_if.sv | 25 ++
 rtl/divisor_tick.sv | 31 +++
 rtl/temporizador_rodada.sv | 118 +++++++++++
 tb/tb_temporizador_rodada.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/temporizador_rodada_pkg.sv
// Shared definitions for the round timer: FSM state codes and default parameter values,
// so the game controller and any bench agree on the same encoding.
package temporizador_rodada_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    ESGOTADO = 2'd2
  } estado_t;

  localparam int TICK_DIV_PADRAO     = 50000000;
  localparam int T_INICIAL_PADRAO    = 10;
  localparam int T_PASSO_PADRAO      = 1;
  localparam int T_MIN_PADRAO        = 3;
  localparam int W_PADRAO            = 8;
  localparam int AVISO_LIMIAR_PADRAO = 3;

endpackage

// File: rtl/temporizador_rodada_if.sv
// Command/status bundle between the game controller (master) and the round timer (slave).
interface temporizador_rodada_if #(
  parameter int W = 8
);

  logic         zeraT;
  logic         contaT;
  logic         decresceT;
  logic         fimT;
  logic [W-1:0] tempo_restante;
  logic [W-1:0] db_limite;
  logic [1:0]   db_estado;
  logic         aviso;

  modport master (
    output zeraT, contaT, decresceT,
    input  fimT, tempo_restante, db_limite, db_estado, aviso
  );

  modport slave (
    input  zeraT, contaT, decresceT,
    output fimT, tempo_restante, db_limite, db_estado, aviso
  );

endinterface

// File: rtl/divisor_tick.sv
// Prescaler for the round timer: counts enabled cycles and pulses tick on the last
// count of each time unit, wrapping to zero on that same edge.
module divisor_tick #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cont;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cont <= '0;
    end else if (clr) begin
      r_cont <= '0;
    end else if (en) begin
      r_cont <= (r_cont == ULTIMO) ? '0 : r_cont + 1'b1;
    end
  end

  // Gated by en so a pause that lands on the last count does not fire a tick.
  assign tick = en && (r_cont == ULTIMO);

endmodule

// File: rtl/temporizador_rodada.sv
// Round countdown timer: PARADO/CONTANDO/ESGOTADO FSM with a shrinking per-round limit.
// Optional low-time warning output enabled by defining TEMPORIZADOR_AVISO_EN.
module temporizador_rodada
  import temporizador_rodada_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_PADRAO,
  parameter int T_INICIAL    = T_INICIAL_PADRAO,
  parameter int T_PASSO      = T_PASSO_PADRAO,
  parameter int T_MIN        = T_MIN_PADRAO,
  parameter int W            = W_PADRAO,
  parameter int AVISO_LIMIAR = AVISO_LIMIAR_PADRAO
) (
  input logic                  clock,
  input logic                  reset,
  temporizador_rodada_if.slave bus
);

  if (TICK_DIV < 2 || T_MIN < 1 || T_MIN > T_INICIAL || T_INICIAL >= 2**W ||
      AVISO_LIMIAR < 0 || AVISO_LIMIAR >= 2**W) begin : g_param_invalido
    $error("temporizador_rodada: inconsistent parameters");
  end

  estado_t      r_estado;
  logic [W-1:0] r_restante;
  logic [W-1:0] r_limite;
  logic         r_fim;
  logic         r_aviso;

  estado_t      w_estado_nx;
  logic [W-1:0] w_restante_nx;
  logic [W-1:0] w_limite_nx;
  logic [W:0]   w_lim_sub;
  logic [W-1:0] w_lim_dec;
  logic         w_tick;
  logic         w_en;
  logic         w_clr;
  logic         w_aviso_nx;

  assign w_en  = (r_estado == CONTANDO) && bus.contaT;
  assign w_clr = bus.zeraT || (r_estado != CONTANDO);

  divisor_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_divisor (
    .clock(clock),
    .reset(reset),
    .clr  (w_clr),
    .en   (w_en),
    .tick (w_tick)
  );

  // One extra bit on the subtraction exposes underflow as the MSB.
  assign w_lim_sub   = {1'b0, r_limite} - (W+1)'(T_PASSO);
  assign w_lim_dec   = (w_lim_sub[W] || (w_lim_sub[W-1:0] < W'(T_MIN))) ? W'(T_MIN)
                                                                         : w_lim_sub[W-1:0];
  assign w_limite_nx = bus.decresceT ? w_lim_dec : r_limite;

  always_comb begin
    w_estado_nx   = r_estado;
    w_restante_nx = r_restante;
    if (bus.zeraT) begin
      w_estado_nx   = PARADO;
      w_restante_nx = w_limite_nx;
    end else begin
      case (r_estado)
        PARADO: begin
          if (bus.contaT) w_estado_nx = CONTANDO;
        end
        CONTANDO: begin
          if (w_tick) begin
            w_restante_nx = r_restante - 1'b1;
            if (r_restante == W'(1)) w_estado_nx = ESGOTADO;
          end
        end
        ESGOTADO: begin
          w_estado_nx = ESGOTADO;
        end
        default: begin
          w_estado_nx = PARADO;
        end
      endcase
    end
  end

`ifdef TEMPORIZADOR_AVISO_EN
  assign w_aviso_nx = (w_estado_nx == CONTANDO) && (w_restante_nx != '0) &&
                      (w_restante_nx <= W'(AVISO_LIMIAR));
`else
  assign w_aviso_nx = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= PARADO;
      r_restante <= W'(T_INICIAL);
      r_limite   <= W'(T_INICIAL);
      r_fim      <= 1'b0;
      r_aviso    <= 1'b0;
    end else begin
      r_estado   <= w_estado_nx;
      r_restante <= w_restante_nx;
      r_limite   <= w_limite_nx;
      // fimT trails the state by one cycle but clears on the same edge as zeraT.
      r_fim      <= !bus.zeraT && (r_estado == ESGOTADO);
      r_aviso    <= w_aviso_nx;
    end
  end

  assign bus.fimT           = r_fim;
  assign bus.tempo_restante = r_restante;
  assign bus.db_limite      = r_limite;
  assign bus.db_estado      = r_estado;
  assign bus.aviso          = r_aviso;

  a_restante_parado: assert property (@(posedge clock) disable iff (!reset)
    (r_estado == PARADO) |-> (r_restante != '0));

endmodule

// File: tb/tb_temporizador_rodada.sv
// Self-checking bench for temporizador_rodada: directed latency/pause/limit cases plus
// randomized commands, all checked every cycle against an abstract time-unit model.
module tb_temporizador_rodada;

  localparam int TD  = 4;
  localparam int TI  = 5;
  localparam int TP  = 1;
  localparam int TM  = 3;
  localparam int WW  = 8;
  localparam int LIM = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  temporizador_rodada_if #(.W(WW)) bus ();

  temporizador_rodada #(
    .TICK_DIV(TD), .T_INICIAL(TI), .T_PASSO(TP), .T_MIN(TM), .W(WW), .AVISO_LIMIAR(LIM)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
    end
  endtask

  // Abstract model: mode 0 idle, 1 running, 2 expired; phase = active cycles in the current unit.
  int m_lim = TI, m_rem = TI, m_mode = 0, m_phase = 0, m_fim = 0;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_lim = TI; m_rem = TI; m_mode = 0; m_phase = 0; m_fim = 0;
    end else begin
      int new_lim;
      int new_fim;
      new_lim = bus.decresceT ? ((m_lim - TP < TM) ? TM : m_lim - TP) : m_lim;
      new_fim = (!bus.zeraT && m_mode == 2) ? 1 : 0;
      if (bus.zeraT) begin
        m_rem = new_lim; m_mode = 0; m_phase = 0;
      end else if (m_mode == 0) begin
        if (bus.contaT) begin m_mode = 1; m_phase = 0; end
      end else if (m_mode == 1 && bus.contaT) begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          m_rem--;
          if (m_rem == 0) m_mode = 2;
        end
      end
      m_lim = new_lim;
      m_fim = new_fim;
    end
  end

  function automatic int aviso_esperado();
`ifdef TEMPORIZADOR_AVISO_EN
    return (m_mode == 1 && m_rem >= 1 && m_rem <= LIM) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    check("restante", bus.tempo_restante, m_rem);
    check("limite",   bus.db_limite,      m_lim);
    check("estado",   bus.db_estado,      m_mode);
    check("fimT",     bus.fimT,           m_fim);
    check("aviso",    bus.aviso,          aviso_esperado());
  end

  task automatic pulso_zera();
    bus.zeraT = 1'b1;
    @(negedge clk);
    bus.zeraT = 1'b0;
  endtask

  // Counts negedges from contaT rising until fimT is seen, with an optional pause window.
  task automatic corre(input int pausa_em, input int pausa_len, output int k);
    bus.contaT = 1'b1;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.fimT === 1'b1) break;
      if (k == pausa_em) bus.contaT = 1'b0;
      if (k == pausa_em + pausa_len) bus.contaT = 1'b1;
    end
  endtask

  initial begin
    int k;
    bus.zeraT = 1'b0; bus.contaT = 1'b0; bus.decresceT = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_restante", bus.tempo_restante, 5);
    check("rst_limite",   bus.db_limite,      5);
    check("rst_estado",   bus.db_estado,      0);
    check("rst_fimT",     bus.fimT,           0);

    bus.decresceT = 1'b1; bus.zeraT = 1'b1;
    @(negedge clk);
    bus.decresceT = 1'b0; bus.zeraT = 1'b0;
    check("dec_zera_restante", bus.tempo_restante, 4);
    check("dec_zera_limite",   bus.db_limite,      4);

    for (int i = 0; i < 3; i++) begin
      bus.decresceT = 1'b1;
      @(negedge clk);
      bus.decresceT = 1'b0;
      check("dec_limite", bus.db_limite, 3);
      check("dec_restante_fixo", bus.tempo_restante, 4);
      @(negedge clk);
    end
    pulso_zera();
    check("zera_restante", bus.tempo_restante, 3);

    corre(0, 0, k);
    check("latencia", k, 14);
    check("expira_restante", bus.tempo_restante, 0);
    check("expira_estado", bus.db_estado, 2);
    repeat (5) @(negedge clk);
    check("esgotado_fimT", bus.fimT, 1);
    bus.contaT = 1'b0;
    pulso_zera();
    check("pos_zera_fimT",     bus.fimT,           0);
    check("pos_zera_restante", bus.tempo_restante, 3);
    check("pos_zera_estado",   bus.db_estado,      0);

    corre(6, 10, k);
    check("latencia_pausa", k, 24);
    bus.contaT = 1'b0;
    pulso_zera();

    bus.contaT = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_restante", bus.tempo_restante, 5);
    check("async_limite",   bus.db_limite,      5);
    check("async_estado",   bus.db_estado,      0);
    check("async_fimT",     bus.fimT,           0);
    bus.contaT = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.contaT    = ($urandom_range(0, 9) < 7);
      bus.zeraT     = ($urandom_range(0, 99) < 2);
      bus.decresceT = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    bus.contaT = 1'b0; bus.zeraT = 1'b0; bus.decresceT = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
